// File: rtl/rf_wb_pkg.sv
// Shared widths and the grant encoding for the register-file write-back arbiter.
package rf_wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_LSU = 1'b1
    } grant_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write bitmap: one bit per architectural register, set on allocation, cleared on write-back.
module rf_scoreboard
    import rf_wb_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_set_en,
    input  logic [REG_ADDR_W-1:0] i_set_idx,
    input  logic                  i_clr_en,
    input  logic [REG_ADDR_W-1:0] i_clr_idx,
    output logic [NUM_REGS-1:0]   o_busy
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_next;

    // Clear is applied before set so a same-cycle allocation of the same register wins.
    always_comb begin
        w_busy_next = r_busy;
        if (i_clr_en) begin
            w_busy_next[i_clr_idx] = 1'b0;
        end
        if (i_set_en) begin
            w_busy_next[i_set_idx] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin ALU/LSU write-back arbiter with registered register-file write port and busy scoreboard.
// Optional same-cycle forwarding port enabled by defining RF_WB_BYPASS_EN.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int XLEN = rf_wb_pkg::XLEN
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_alu_valid,
    output logic                  o_alu_ready,
    input  logic [REG_ADDR_W-1:0] i_alu_rd,
    input  logic [XLEN-1:0]       i_alu_data,
    input  logic                  i_lsu_valid,
    output logic                  o_lsu_ready,
    input  logic [REG_ADDR_W-1:0] i_lsu_rd,
    input  logic [XLEN-1:0]       i_lsu_data,
    input  logic                  i_alloc_valid,
    input  logic [REG_ADDR_W-1:0] i_alloc_rd,
    output logic [NUM_REGS-1:0]   o_busy,
    output logic                  o_regwr,
    output logic [REG_ADDR_W-1:0] o_wr_rd,
    output logic [XLEN-1:0]       o_wrdata
`ifdef RF_WB_BYPASS_EN
    ,
    output logic                  o_byp_valid,
    output logic [REG_ADDR_W-1:0] o_byp_rd,
    output logic [XLEN-1:0]       o_byp_data
`endif
);

    grant_e                r_last_grant;
    grant_e                w_last_grant_next;
    logic                  w_alu_ready;
    logic                  w_lsu_ready;
    logic                  w_alu_acc;
    logic                  w_lsu_acc;
    logic [REG_ADDR_W-1:0] w_acc_rd;
    logic [XLEN-1:0]       w_acc_data;
    logic                  w_wr_en;

    logic                  r_regwr;
    logic [REG_ADDR_W-1:0] r_wr_rd;
    logic [XLEN-1:0]       r_wrdata;

    // On contention the side that did not win last time gets the grant; nothing is granted in reset.
    always_comb begin
        w_alu_ready = 1'b0;
        w_lsu_ready = 1'b0;
        if (i_rst) begin
            w_alu_ready = i_alu_valid && (!i_lsu_valid || (r_last_grant == GNT_LSU));
            w_lsu_ready = i_lsu_valid && (!i_alu_valid || (r_last_grant == GNT_ALU));
        end
    end

    assign w_alu_acc  = w_alu_ready;
    assign w_lsu_acc  = w_lsu_ready;
    assign w_acc_rd   = w_alu_acc ? i_alu_rd   : i_lsu_rd;
    assign w_acc_data = w_alu_acc ? i_alu_data : i_lsu_data;
    assign w_wr_en    = (w_alu_acc || w_lsu_acc) && (w_acc_rd != '0);

    always_comb begin
        w_last_grant_next = r_last_grant;
        if (w_alu_acc) begin
            w_last_grant_next = GNT_ALU;
        end else if (w_lsu_acc) begin
            w_last_grant_next = GNT_LSU;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_last_grant <= GNT_LSU;
        end else begin
            r_last_grant <= w_last_grant_next;
        end
    end

    // Index and data only move on a real write so an idle port keeps showing the last write.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_regwr  <= 1'b0;
            r_wr_rd  <= '0;
            r_wrdata <= '0;
        end else begin
            r_regwr <= w_wr_en;
            if (w_wr_en) begin
                r_wr_rd  <= w_acc_rd;
                r_wrdata <= w_acc_data;
            end
        end
    end

    rf_scoreboard u_scoreboard (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_set_en  (i_alloc_valid),
        .i_set_idx (i_alloc_rd),
        .i_clr_en  (w_wr_en),
        .i_clr_idx (w_acc_rd),
        .o_busy    (o_busy)
    );

    assign o_alu_ready = w_alu_ready;
    assign o_lsu_ready = w_lsu_ready;
    assign o_regwr     = r_regwr;
    assign o_wr_rd     = r_wr_rd;
    assign o_wrdata    = r_wrdata;

`ifdef RF_WB_BYPASS_EN
    assign o_byp_valid = w_wr_en;
    assign o_byp_rd    = w_acc_rd;
    assign o_byp_data  = w_acc_data;
`endif

endmodule
